ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have ports: clk  in  1  clock; resetn  in  1  reset, synchronous, active-low.
REQ-002 SHALL have ports: ireq_1  out  ibus_req_t  first-word fetch request; ireq_2  out  ibus_req_t  second-word fetch request; iresp  in  ibus_resp_t  icache response (addr_ok, data_ok, 64-bit data = {word2, word1}).
REQ-003 SHALL have ports: redirect_valid  in  1  flush and refetch; redirect_pc  in  32  new fetch PC.
REQ-004 SHALL have ports: out_valid  out  2  per-slot valid, bit0 = head, bit1 = head+1; out_pc0, out_pc1  out  32 each  PCs; out_inst0, out_inst1  out  32 each  instructions; deq_cnt  in  2  entries consumed this cycle, 0..2.
REQ-005 SHALL have parameters: RESET_PC, default 32'hBFC0_0000, first fetch address; DEPTH, default 8, power of two, >= 4, queue entries of {pc, inst}.

Function
REQ-006 SHALL run a 3-state FSM: IDLE, REQ (request asserted, awaiting addr_ok), WAIT (awaiting data_ok).
REQ-007 IDLE->REQ SHALL occur when free slots >= 2 and no redirect this cycle; free = DEPTH - count.
REQ-008 In REQ, ireq_1.valid and ireq_2.valid SHALL be 1; ireq_1.addr = fpc, ireq_2.addr = fpc+4, from a register latched on entry to REQ; all other request fields SHALL be 0.
REQ-009 Request addresses SHALL stay constant from REQ entry until addr_ok, even across redirects; icache has no abort.
REQ-010 REQ->WAIT SHALL occur on iresp.addr_ok; ireq valid SHALL drop the same cycle (combinational from state).
REQ-011 WAIT->IDLE SHALL occur on iresp.data_ok; unless discard is set, data[31:0] with pc fpc and data[63:32] with pc fpc+4 SHALL be enqueued in that order, and pc SHALL advance by 8.
REQ-012 The 2 slots for an in-flight pair SHALL be reserved from REQ entry; the queue SHALL never overflow.
REQ-013 Queue SHALL be a circular buffer: 3-bit head/tail pointers (log2 DEPTH) wrapping modulo DEPTH, plus (log2 DEPTH + 1)-bit count.
REQ-014 out_valid[0] = count >= 1; out_valid[1] = count >= 2; outputs SHALL be combinational from head, head+1 (wrapping).
REQ-015 deq_cnt > valid entries is illegal; the design SHALL clamp it to count.
REQ-016 Same-cycle enqueue of 2 and dequeue of N SHALL give count' = count + 2 - N.
REQ-017 redirect_valid SHALL, the same edge: empty the queue (head = tail, count = 0), set pc = {redirect_pc[31:2], 2'b00}, override any enqueue/dequeue that cycle.
REQ-018 A redirect in REQ or WAIT SHALL set discard; the pending pair SHALL be dropped on data_ok; discard SHALL clear on data_ok.
REQ-019 A redirect coinciding with data_ok SHALL drop that data, set pc to the redirect target, leave discard clear, and go to IDLE.
REQ-020 Successive redirects SHALL keep only the latest target.
REQ-021 pc+4 / pc+8 SHALL wrap modulo 2^32.

Reset
REQ-022 On resetn=0 at clk edge: state = IDLE, pc = RESET_PC, fpc = RESET_PC, head = tail = count = 0, discard = 0.
REQ-023 During and right after reset: ireq_1.valid = ireq_2.valid = 0, out_valid = 2'b00.
REQ-024 Reset mid-transaction SHALL abandon the pair; responses arriving after reset SHALL be ignored until the next REQ.

Verification
REQ-025 Reset, icache model with addr_ok 3 cycles after request and data_ok 1 cycle later, data 64'h2222_2222_1111_1111 -> ireq addrs BFC00000/BFC00004; out_pc0 = BFC00000, inst0 = 11111111; out_pc1 = BFC00004, inst1 = 22222222; next request at BFC00008.
REQ-026 deq_cnt = 0 forever -> exactly DEPTH/2 = 4 pairs fetched, count = 8, no further ireq valid; then deq_cnt = 2 for one cycle -> exactly one new request issues.
REQ-027 Redirect to 8000_0102 during REQ -> addrs unchanged until addr_ok; pair dropped; queue empty; next request 8000_0100/8000_0104.
REQ-028 Redirect in the same cycle as data_ok -> nothing enqueued, out_valid = 00, next request at redirect target.
REQ-029 count = 1, data_ok and deq_cnt = 1 together -> count = 2, head = old entry slot+1, outputs show the new pair.
REQ-030 Redirect to FFFF_FFF8, then a fetch -> pcs FFFFFFF8/FFFFFFFC, next fetch at 0000_0000.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front end. Issues paired two-word fetch
// requests to the icache and buffers returned {pc, inst} pairs in a circular
// queue that the decoder drains up to two entries per cycle.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   ireq_1, ireq_2         first/second word fetch requests (valid in REQ)
//   iresp                  icache response: addr_ok, data_ok, data = {word2, word1}
//   redirect_valid/_pc     flush the queue and refetch from a new PC
//   out_valid[1:0]         bit0 = head valid, bit1 = head+1 valid
//   out_pc0/1, out_inst0/1 head and head+1 entries
//   deq_cnt                entries consumed this cycle (clamped to count)

package ifetch_queue_pkg;

    typedef struct packed {
        logic        valid;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } ibus_resp_t;

endpackage

module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned DEPTH    = 8
) (
    input  logic        clk,
    input  logic        resetn,

    output ibus_req_t   ireq_1,
    output ibus_req_t   ireq_2,
    input  ibus_resp_t  iresp,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic [1:0]  out_valid,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    output logic [31:0] out_inst0,
    output logic [31:0] out_inst1,
    input  logic [1:0]  deq_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        fpc_q, fpc_d;
    logic               discard_q, discard_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               enq;
    logic [CNT_W-1:0]   deq_eff;
    logic [CNT_W-1:0]   free_slots;
    logic [PTR_W-1:0]   head_p1;
    logic [PTR_W-1:0]   tail_p1;

    logic [31:0]        pc_mem   [DEPTH];
    logic [31:0]        inst_mem [DEPTH];

    // Low PC bits of a redirect are forced to word alignment and otherwise ignored.
    logic               unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign free_slots = CNT_W'(DEPTH) - count_q;
    assign head_p1    = head_q + PTR_W'(1);
    assign tail_p1    = tail_q + PTR_W'(1);

    // State and queue bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            fpc_q     <= RESET_PC;
            discard_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fpc_q     <= fpc_d;
            discard_q <= discard_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Next-state, pointer and PC logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fpc_d     = fpc_q;
        discard_d = discard_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        enq       = 1'b0;

        // Over-asking dequeues are clamped to what is actually held.
        deq_eff = (CNT_W'(deq_cnt) > count_q) ? count_q : CNT_W'(deq_cnt);

        unique case (state_q)
            IDLE: begin
                // Two free slots are reserved for the pair from this point on.
                if (!redirect_valid && (free_slots >= CNT_W'(2))) begin
                    state_d = REQ;
                    fpc_d   = pc_q;
                end
            end
            REQ: begin
                if (iresp.addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (iresp.data_ok) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    enq       = !discard_q && !redirect_valid;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enq) begin
            pc_d   = fpc_q + 32'd8;
            tail_d = tail_q + PTR_W'(2);
        end
        head_d  = head_q + PTR_W'(deq_eff);
        count_d = count_q + (enq ? CNT_W'(2) : CNT_W'(0)) - deq_eff;

        // Redirect wins over any enqueue/dequeue; an in-flight pair cannot be
        // aborted at the icache, so it is marked for dropping instead.
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            head_d  = tail_q;
            tail_d  = tail_q;
            count_d = '0;
            if ((state_q == REQ) || ((state_q == WAIT) && !iresp.data_ok)) begin
                discard_d = 1'b1;
            end
        end
    end

    // Queue storage; the pair lands in tail and tail+1.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail_q]    <= fpc_q;
            inst_mem[tail_q]  <= iresp.data[31:0];
            pc_mem[tail_p1]   <= fpc_q + 32'd4;
            inst_mem[tail_p1] <= iresp.data[63:32];
        end
    end

    // Fetch requests are combinational from state so valid drops with addr_ok.
    always_comb begin
        ireq_1       = '0;
        ireq_2       = '0;
        ireq_1.valid = (state_q == REQ);
        ireq_2.valid = (state_q == REQ);
        ireq_1.addr  = fpc_q;
        ireq_2.addr  = fpc_q + 32'd4;
    end

    assign out_valid[0] = (count_q >= CNT_W'(1));
    assign out_valid[1] = (count_q >= CNT_W'(2));
    assign out_pc0      = pc_mem[head_q];
    assign out_inst0    = inst_mem[head_q];
    assign out_pc1      = pc_mem[head_p1];
    assign out_inst1    = inst_mem[head_p1];

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: icache responder model plus directed scenarios.
module tb_ifetch_queue;
    import ifetch_queue_pkg::*;

    logic        clk;
    logic        resetn;
    ibus_req_t   ireq_1, ireq_2;
    ibus_resp_t  iresp, icm_resp, man_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  out_valid;
    logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1;
    logic [1:0]  deq_cnt;

    logic        icm_en;
    logic [31:0] icm_addr;
    int          icm_cnt;
    int          addr_moved;
    logic [31:0] req_log[$];
    logic [31:0] req2_log[$];
    logic [63:0] exp_q[$];

    int errors = 0;
    int checks = 0;

    ifetch_queue dut (
        .clk            (clk),
        .resetn         (resetn),
        .ireq_1         (ireq_1),
        .ireq_2         (ireq_2),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc0        (out_pc0),
        .out_pc1        (out_pc1),
        .out_inst0      (out_inst0),
        .out_inst1      (out_inst1),
        .deq_cnt        (deq_cnt)
    );

    assign iresp = icm_en ? icm_resp : man_resp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1);
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h1111_1111;
        if (a == 32'hBFC0_0004) return 32'h2222_2222;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // icache model: addr_ok on the 3rd cycle of a request, data_ok the cycle after.
    initial begin
        icm_resp   = '0;
        icm_cnt    = 0;
        icm_addr   = '0;
        addr_moved = 0;
        forever begin
            @(negedge clk);
            icm_resp.data_ok = 1'b0;
            if (!icm_en || !resetn) begin
                icm_resp = '0;
                icm_cnt  = 0;
            end else if (icm_resp.addr_ok) begin
                icm_resp.addr_ok = 1'b0;
                icm_resp.data_ok = 1'b1;
                icm_resp.data    = {inst_of(icm_addr + 32'd4), inst_of(icm_addr)};
                exp_q.push_back({icm_addr, inst_of(icm_addr)});
                exp_q.push_back({icm_addr + 32'd4, inst_of(icm_addr + 32'd4)});
            end else if (ireq_1.valid) begin
                if (icm_cnt == 0) icm_addr = ireq_1.addr;
                else if (ireq_1.addr != icm_addr) addr_moved++;
                icm_cnt++;
                if (icm_cnt == 3) begin
                    icm_resp.addr_ok = 1'b1;
                    req_log.push_back(ireq_1.addr);
                    req2_log.push_back(ireq_2.addr);
                    icm_cnt = 0;
                end
            end
        end
    end

    task automatic do_reset();
        resetn         = 1'b0;
        icm_en         = 1'b0;
        man_resp       = '0;
        deq_cnt        = 2'd0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) @(negedge clk);
    endtask

    // Manually answers one request: addr_ok, then data_ok with optional
    // dequeue and redirect in the data_ok cycle. Returns one cycle after data_ok.
    task automatic manual_fetch(input logic [63:0] data, input logic [1:0] deq_at_data,
                                input logic redir, input logic [31:0] rpc);
        int n = 0;
        while (!ireq_1.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ireq_1.valid) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: ireq_1.valid=%0b want 1", ireq_1.valid);
        end
        man_resp.addr_ok = 1'b1;
        @(negedge clk);
        man_resp.addr_ok = 1'b0;
        man_resp.data_ok = 1'b1;
        man_resp.data    = data;
        deq_cnt          = deq_at_data;
        if (redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = rpc;
        end
        @(negedge clk);
        man_resp.data_ok = 1'b0;
        deq_cnt          = 2'd0;
        redirect_valid   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ireq_1.valid, ireq_2.valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ireq_valid: got %b want 00", {ireq_1.valid, ireq_2.valid});
        end
        checks++;
        if (out_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 00", out_valid);
        end
        // Stale data_ok right at release must be ignored.
        man_resp.data_ok = 1'b1;
        man_resp.data    = 64'hDEAD_BEEF_DEAD_BEEF;
        resetn = 1'b1;
        @(negedge clk);
        man_resp.data_ok = 1'b0;
        checks++;
        if (out_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_stale_data: out_valid got %b want 00", out_valid);
        end
        checks++;
        if (!ireq_1.valid || ireq_1.addr !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL reset_first_req: valid=%b addr=%h want 1 BFC00000", ireq_1.valid, ireq_1.addr);
        end
        // Reset while waiting for data abandons the pair.
        man_resp.addr_ok = 1'b1;
        @(negedge clk);
        man_resp.addr_ok = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        man_resp.data_ok = 1'b1;
        resetn = 1'b1;
        @(negedge clk);
        man_resp.data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_txn: out_valid got %b want 00", out_valid);
        end
    endtask

    task automatic test_basic();
        int n = 0;
        do_reset();
        icm_en = 1'b1;
        resetn = 1'b1;
        while (exp_q.size() < 2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (req_log.size() < 1 || req_log[0] !== 32'hBFC0_0000 || req2_log[0] !== 32'hBFC0_0004) begin
            errors++;
            $display("FAIL basic_req_addr: got %0d reqs first %h/%h want BFC00000/BFC00004",
                     req_log.size(), req_log[0], req2_log[0]);
        end
        checks++;
        if (out_valid !== 2'b11 || out_pc0 !== 32'hBFC0_0000 || out_inst0 !== 32'h1111_1111) begin
            errors++;
            $display("FAIL basic_slot0: valid=%b pc=%h inst=%h want 11 BFC00000 11111111",
                     out_valid, out_pc0, out_inst0);
        end
        checks++;
        if (out_pc1 !== 32'hBFC0_0004 || out_inst1 !== 32'h2222_2222) begin
            errors++;
            $display("FAIL basic_slot1: pc=%h inst=%h want BFC00004 22222222", out_pc1, out_inst1);
        end
        n = 0;
        while (req_log.size() < 2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_log.size() < 2 || req_log[1] !== 32'hBFC0_0008) begin
            errors++;
            $display("FAIL basic_next_req: got %0d reqs addr %h want BFC00008", req_log.size(), req_log[1]);
        end
    endtask

    task automatic test_full();
        repeat (80) @(negedge clk);
        checks++;
        if (req_log.size() != 4 || ireq_1.valid !== 1'b0 || out_valid !== 2'b11) begin
            errors++;
            $display("FAIL full_stall: reqs=%0d valid=%b out_valid=%b want 4 0 11",
                     req_log.size(), ireq_1.valid, out_valid);
        end
        checks++;
        if ({out_pc0, out_inst0, out_pc1, out_inst1} !== {exp_q[0], exp_q[1]}) begin
            errors++;
            $display("FAIL full_head: got %h %h want %h %h", out_pc0, out_pc1, exp_q[0][63:32], exp_q[1][63:32]);
        end
        deq_cnt = 2'd2;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        @(negedge clk);
        deq_cnt = 2'd0;
        repeat (40) @(negedge clk);
        checks++;
        if (req_log.size() != 5 || ireq_1.valid !== 1'b0 || req_log[4] !== 32'hBFC0_0020) begin
            errors++;
            $display("FAIL full_one_more: reqs=%0d valid=%b last=%h want 5 0 BFC00020",
                     req_log.size(), ireq_1.valid, req_log[4]);
        end
        checks++;
        if (addr_moved != 0) begin
            errors++;
            $display("FAIL addr_stable: moved=%0d want 0", addr_moved);
        end
    endtask

    // Random dequeues (including over-asks) against the scoreboard.
    task automatic test_drain();
        logic [1:0] d;
        int nv;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            nv = out_valid[1] ? 2 : (out_valid[0] ? 1 : 0);
            if (out_valid[0]) begin
                checks++;
                if (exp_q.size() < 1 || {out_pc0, out_inst0} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL drain_slot0: got %h/%h want %h", out_pc0, out_inst0, exp_q[0]);
                end
            end
            if (out_valid[1]) begin
                checks++;
                if (exp_q.size() < 2 || {out_pc1, out_inst1} !== exp_q[1]) begin
                    errors++;
                    $display("FAIL drain_slot1: got %h/%h want %h", out_pc1, out_inst1, exp_q[1]);
                end
            end
            d = 2'($urandom_range(0, 2));
            deq_cnt = d;
            for (int k = 0; k < ((int'(d) < nv) ? int'(d) : nv); k++) void'(exp_q.pop_front());
        end
        deq_cnt = 2'd0;
    endtask

    task automatic test_redirect_req();
        do_reset();
        resetn = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (!ireq_1.valid || ireq_1.addr !== 32'hBFC0_0000 || ireq_2.addr !== 32'hBFC0_0004) begin
            errors++;
            $display("FAIL redir_req_hold: valid=%b addr=%h/%h want 1 BFC00000/BFC00004",
                     ireq_1.valid, ireq_1.addr, ireq_2.addr);
        end
        manual_fetch(64'h3333_3333_4444_4444, 2'd0, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 2'b00) begin
            errors++;
            $display("FAIL redir_req_drop: out_valid got %b want 00", out_valid);
        end
        @(negedge clk);
        checks++;
        if (!ireq_1.valid || ireq_1.addr !== 32'h8000_0100 || ireq_2.addr !== 32'h8000_0104) begin
            errors++;
            $display("FAIL redir_req_target: valid=%b addr=%h/%h want 1 80000100/80000104",
                     ireq_1.valid, ireq_1.addr, ireq_2.addr);
        end
        manual_fetch(64'h5555_5555_6666_6666, 2'd0, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 2'b11 || out_pc0 !== 32'h8000_0100 || out_inst0 !== 32'h6666_6666) begin
            errors++;
            $display("FAIL redir_req_refill: valid=%b pc=%h inst=%h want 11 80000100 66666666",
                     out_valid, out_pc0, out_inst0);
        end
    endtask

    task automatic test_redirect_dataok();
        do_reset();
        resetn = 1'b1;
        manual_fetch(64'h7777_7777_8888_8888, 2'd0, 1'b1, 32'h1234_5679);
        checks++;
        if (out_valid !== 2'b00 || ireq_1.valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_data_drop: out_valid=%b valid=%b want 00 0", out_valid, ireq_1.valid);
        end
        @(negedge clk);
        checks++;
        if (!ireq_1.valid || ireq_1.addr !== 32'h1234_5678) begin
            errors++;
            $display("FAIL redir_data_target: valid=%b addr=%h want 1 12345678", ireq_1.valid, ireq_1.addr);
        end
        manual_fetch(64'h9999_9999_AAAA_AAAA, 2'd0, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 2'b11 || out_pc0 !== 32'h1234_5678 || out_inst1 !== 32'h9999_9999) begin
            errors++;
            $display("FAIL redir_data_nodiscard: valid=%b pc0=%h inst1=%h want 11 12345678 99999999",
                     out_valid, out_pc0, out_inst1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        resetn = 1'b1;
        manual_fetch(64'h0000_00B2_0000_00B1, 2'd0, 1'b0, 32'h0);
        deq_cnt = 2'd1;
        @(negedge clk);
        deq_cnt = 2'd0;
        checks++;
        if (out_valid !== 2'b01 || out_pc0 !== 32'hBFC0_0004 || out_inst0 !== 32'h0000_00B2) begin
            errors++;
            $display("FAIL b2b_one_left: valid=%b pc=%h inst=%h want 01 BFC00004 000000B2",
                     out_valid, out_pc0, out_inst0);
        end
        manual_fetch(64'h0000_00C2_0000_00C1, 2'd1, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 2'b11 || out_pc0 !== 32'hBFC0_0008 || out_inst0 !== 32'h0000_00C1) begin
            errors++;
            $display("FAIL b2b_slot0: valid=%b pc=%h inst=%h want 11 BFC00008 000000C1",
                     out_valid, out_pc0, out_inst0);
        end
        checks++;
        if (out_pc1 !== 32'hBFC0_000C || out_inst1 !== 32'h0000_00C2) begin
            errors++;
            $display("FAIL b2b_slot1: pc=%h inst=%h want BFC0000C 000000C2", out_pc1, out_inst1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        resetn = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1111_1110;
        @(negedge clk);
        redirect_pc    = 32'hFFFF_FFFB;
        @(negedge clk);
        redirect_valid = 1'b0;
        manual_fetch(64'h0, 2'd0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (!ireq_1.valid || ireq_1.addr !== 32'hFFFF_FFF8 || ireq_2.addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req: valid=%b addr=%h/%h want 1 FFFFFFF8/FFFFFFFC",
                     ireq_1.valid, ireq_1.addr, ireq_2.addr);
        end
        manual_fetch(64'hAAAA_0002_BBBB_0001, 2'd0, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 2'b11 || out_pc0 !== 32'hFFFF_FFF8 || out_pc1 !== 32'hFFFF_FFFC
            || out_inst0 !== 32'hBBBB_0001) begin
            errors++;
            $display("FAIL wrap_entries: valid=%b pc=%h/%h inst0=%h want 11 FFFFFFF8/FFFFFFFC BBBB0001",
                     out_valid, out_pc0, out_pc1, out_inst0);
        end
        @(negedge clk);
        checks++;
        if (!ireq_1.valid || ireq_1.addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_next: valid=%b addr=%h want 1 00000000", ireq_1.valid, ireq_1.addr);
        end
    endtask

    initial begin
        resetn         = 1'b0;
        icm_en         = 1'b0;
        man_resp       = '0;
        deq_cnt        = 2'd0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        test_reset();
        test_basic();
        test_full();
        test_drain();
        test_redirect_req();
        test_redirect_dataok();
        test_back_to_back();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
